// File: rtl/clip_monitor_pkg.sv
// Shared DSP helpers: full-scale code generators for saturating narrowers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Package: clip_monitor_pkg
//   pos_full_scale(width) : +max code, 0 followed by width-1 ones.
//   neg_full_scale(width) : -max code, 1 followed by width-1 zeros.
// Both return a 64-bit value; callers keep the low 'width' bits.
package clip_monitor_pkg;

    function automatic logic [63:0] pos_full_scale(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] neg_full_scale(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/clip_monitor_clip_detect.sv
// Per-channel full-scale detector with saturating absolute value.
// Latency: combinational.
// Backpressure: none; evaluates whatever sample is presented.
//
// Module: clip_detect (macro CLIP_MONITOR_PEAK_EN adds the mag output)
//   sample : two's complement input sample
//   clip   : sample equals +max or -max
//   mag    : |sample|, with |-max| saturated to +max (peak builds only)
module clip_detect
    import clip_monitor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] sample,
    output logic             clip
`ifdef CLIP_MONITOR_PEAK_EN
    ,
    output logic [WIDTH-2:0] mag
`endif
);

    localparam logic [63:0]      POS_FS_W = pos_full_scale(WIDTH);
    localparam logic [63:0]      NEG_FS_W = neg_full_scale(WIDTH);
    localparam logic [WIDTH-1:0] POS_FS   = POS_FS_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] NEG_FS   = NEG_FS_W[WIDTH-1:0];

    assign clip = (sample == POS_FS) || (sample == NEG_FS);

`ifdef CLIP_MONITOR_PEAK_EN
    // For any negative sample other than -max, |sample| < 2^(WIDTH-1), so
    // negating only the low WIDTH-1 bits gives the exact magnitude.
    logic [WIDTH-2:0] neg_low;
    assign neg_low = -sample[WIDTH-2:0];

    always_comb begin
        mag = sample[WIDTH-2:0];
        if (sample == NEG_FS) begin
            mag = POS_FS[WIDTH-2:0];
        end else if (sample[WIDTH-1]) begin
            mag = neg_low;
        end
    end
`endif

endmodule

// File: rtl/clip_monitor.sv
// I/Q clip monitor: registered pass-through plus windowed clip statistics.
// Latency: 1 cycle for data/strobe; stats publish 1 cycle after window end.
// Backpressure: none; accepts a strobed sample every cycle, gaps allowed.
//
// Module: clip_monitor (macro CLIP_MONITOR_PEAK_EN enables peak tracking)
//   clk, rst             : clock, synchronous active-high reset
//   clear                : restart window, zero stats, drop clip_flag
//   strobe_in/in_i/in_q  : input sample stream
//   strobe_out/out_i/q   : same stream delayed by one register stage
//   clip_flag            : sticky, set by any clipped sample
//   clip_count, peak     : results of the last completed window
//   window_done          : one-cycle pulse when clip_count/peak update
module clip_monitor
    import clip_monitor_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int WINDOW_LOG2 = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   strobe_in,
    input  logic [WIDTH-1:0]       in_i,
    input  logic [WIDTH-1:0]       in_q,
    output logic                   strobe_out,
    output logic [WIDTH-1:0]       out_i,
    output logic [WIDTH-1:0]       out_q,
    output logic                   clip_flag,
    output logic [WINDOW_LOG2:0]   clip_count,
    output logic [WIDTH-2:0]       peak,
    output logic                   window_done
);

    logic                   clip_i;
    logic                   clip_q;
    logic                   take;       // strobed sample that counts toward stats
    logic                   clip_hit;
    logic                   win_last;
    logic [WINDOW_LOG2-1:0] win_cnt;
    logic [WINDOW_LOG2:0]   run_cnt;
    logic [WINDOW_LOG2:0]   cnt_next;

`ifdef CLIP_MONITOR_PEAK_EN
    logic [WIDTH-2:0] mag_i;
    logic [WIDTH-2:0] mag_q;
    logic [WIDTH-2:0] mag_max;
    logic [WIDTH-2:0] peak_next;
    logic [WIDTH-2:0] run_peak;

    clip_detect #(.WIDTH(WIDTH)) u_det_i (.sample(in_i), .clip(clip_i), .mag(mag_i));
    clip_detect #(.WIDTH(WIDTH)) u_det_q (.sample(in_q), .clip(clip_q), .mag(mag_q));

    assign mag_max   = (mag_i > mag_q) ? mag_i : mag_q;
    assign peak_next = (mag_max > run_peak) ? mag_max : run_peak;
`else
    clip_detect #(.WIDTH(WIDTH)) u_det_i (.sample(in_i), .clip(clip_i));
    clip_detect #(.WIDTH(WIDTH)) u_det_q (.sample(in_q), .clip(clip_q));
`endif

    // clear overrides a coincident strobe for statistics only.
    assign take     = strobe_in & ~clear;
    assign clip_hit = take & (clip_i | clip_q);
    assign win_last = &win_cnt;
    assign cnt_next = run_cnt + {{WINDOW_LOG2{1'b0}}, clip_hit};

    // Pass-through stage: unaffected by clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_out <= 1'b0;
            out_i      <= '0;
            out_q      <= '0;
        end else begin
            strobe_out <= strobe_in;
            if (strobe_in) begin
                out_i <= in_i;
                out_q <= in_q;
            end
        end
    end

    // Window statistics. The window counter wraps to 0 by itself on the
    // last sample, so no explicit restart is needed for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt     <= '0;
            run_cnt     <= '0;
            clip_count  <= '0;
            clip_flag   <= 1'b0;
            window_done <= 1'b0;
        end else begin
            window_done <= 1'b0;
            if (clear) begin
                win_cnt    <= '0;
                run_cnt    <= '0;
                clip_count <= '0;
                clip_flag  <= 1'b0;
            end else if (take) begin
                win_cnt <= win_cnt + 1'b1;
                if (clip_hit) begin
                    clip_flag <= 1'b1;
                end
                if (win_last) begin
                    clip_count  <= cnt_next;
                    run_cnt     <= '0;
                    window_done <= 1'b1;
                end else begin
                    run_cnt <= cnt_next;
                end
            end
        end
    end

`ifdef CLIP_MONITOR_PEAK_EN
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            run_peak <= '0;
            peak     <= '0;
        end else if (take) begin
            if (win_last) begin
                peak     <= peak_next;
                run_peak <= '0;
            end else begin
                run_peak <= peak_next;
            end
        end
    end
`else
    assign peak = '0;
`endif

endmodule

// File: tb/tb_clip_monitor.sv
// Directed self-checking bench for clip_monitor (WIDTH=16, WINDOW_LOG2=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// Peak expectations follow CLIP_MONITOR_PEAK_EN.
module tb_clip_monitor;

    localparam int W  = 16;
    localparam int WL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          strobe_in = 1'b0;
    logic [W-1:0]  in_i = '0;
    logic [W-1:0]  in_q = '0;
    logic          strobe_out;
    logic [W-1:0]  out_i;
    logic [W-1:0]  out_q;
    logic          clip_flag;
    logic [WL:0]   clip_count;
    logic [W-2:0]  peak;
    logic          window_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clip_monitor #(.WIDTH(W), .WINDOW_LOG2(WL)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .strobe_in  (strobe_in),
        .in_i       (in_i),
        .in_q       (in_q),
        .strobe_out (strobe_out),
        .out_i      (out_i),
        .out_q      (out_q),
        .clip_flag  (clip_flag),
        .clip_count (clip_count),
        .peak       (peak),
        .window_done(window_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [W-1:0] i, input logic [W-1:0] q);
        strobe_in = s;
        in_i      = i;
        in_q      = q;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; strobe_in = 1'b0; in_i = '0; in_q = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; clear = 1'b0;
        drive(1'b1, 16'h7FFF, 16'h7FFF);
        rst = 1'b1;
        drive(1'b1, 16'h1234, 16'h8000);
        total++; if (strobe_out !== 1'b0) begin bad++; $display("FAIL reset_strobe_out got=%0h exp=0", strobe_out); end
        total++; if (out_i !== 16'h0) begin bad++; $display("FAIL reset_out_i got=%0h exp=0", out_i); end
        total++; if (out_q !== 16'h0) begin bad++; $display("FAIL reset_out_q got=%0h exp=0", out_q); end
        total++; if (clip_flag !== 1'b0) begin bad++; $display("FAIL reset_clip_flag got=%0h exp=0", clip_flag); end
        total++; if (clip_count !== 5'd0) begin bad++; $display("FAIL reset_clip_count got=%0h exp=0", clip_count); end
        total++; if (peak !== 15'd0) begin bad++; $display("FAIL reset_peak got=%0h exp=0", peak); end
        total++; if (window_done !== 1'b0) begin bad++; $display("FAIL reset_window_done got=%0h exp=0", window_done); end
        rst = 1'b0; strobe_in = 1'b0;
    endtask

    // Samples 3 and 9 clip on I, sample 9 also clips on Q: count is 2.
    task automatic test_clip_window();
        logic [W-1:0] vi, vq;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            vi = (k == 3 || k == 9) ? 16'h7FFF : 16'h0100;
            vq = (k == 9) ? 16'h8000 : 16'h0100;
            drive(1'b1, vi, vq);
            total++; if (clip_flag !== (k >= 3)) begin bad++; $display("FAIL clipwin_flag k=%0d got=%0h exp=%0h", k, clip_flag, (k >= 3)); end
            total++; if (window_done !== (k == 16)) begin bad++; $display("FAIL clipwin_done k=%0d got=%0h exp=%0h", k, window_done, (k == 16)); end
        end
        total++; if (clip_count !== 5'd2) begin bad++; $display("FAIL clipwin_count got=%0d exp=2", clip_count); end
        drive(1'b0, 16'h0, 16'h0);
        total++; if (window_done !== 1'b0) begin bad++; $display("FAIL clipwin_done_pulse got=%0h exp=0", window_done); end
        total++; if (clip_flag !== 1'b1) begin bad++; $display("FAIL clipwin_flag_sticky got=%0h exp=1", clip_flag); end
    endtask

    task automatic test_continuous();
        logic [W-1:0] prev;
        int dones;
        do_reset();
        dones = 0;
        prev  = '0;
        for (int k = 1; k <= 48; k++) begin
            strobe_in = 1'b1;
            in_i = 16'h0040 + W'(k);
            in_q = 16'hFF00 - W'(k);
            #1;
            total++; if (out_i !== prev) begin bad++; $display("FAIL cont_hold k=%0d got=%0h exp=%0h", k, out_i, prev); end
            tick();
            prev = 16'h0040 + W'(k);
            total++; if (out_i !== prev) begin bad++; $display("FAIL cont_out_i k=%0d got=%0h exp=%0h", k, out_i, prev); end
            total++; if (window_done !== (k % 16 == 0)) begin bad++; $display("FAIL cont_done k=%0d got=%0h exp=%0h", k, window_done, (k % 16 == 0)); end
            if (window_done === 1'b1) dones++;
        end
        total++; if (dones !== 3) begin bad++; $display("FAIL cont_done_count got=%0d exp=3", dones); end
        total++; if (clip_count !== 5'd0) begin bad++; $display("FAIL cont_clip_count got=%0d exp=0", clip_count); end
        total++; if (clip_flag !== 1'b0) begin bad++; $display("FAIL cont_clip_flag got=%0h exp=0", clip_flag); end
        strobe_in = 1'b0;
    endtask

    task automatic test_peak();
        logic [W-2:0] exp1, exp2;
`ifdef CLIP_MONITOR_PEAK_EN
        exp1 = 15'h7FFF;
        exp2 = 15'h0200;
`else
        exp1 = 15'h0;
        exp2 = 15'h0;
`endif
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            if (k == 1) drive(1'b1, 16'h8000, 16'h1234);
            else        drive(1'b1, 16'h0010, 16'hFFF0);
        end
        total++; if (peak !== exp1) begin bad++; $display("FAIL peak_win1 got=%0h exp=%0h", peak, exp1); end
        total++; if (clip_count !== 5'd1) begin bad++; $display("FAIL peak_win1_count got=%0d exp=1", clip_count); end
        for (int k = 1; k <= 16; k++) begin
            if (k == 1)      drive(1'b1, 16'h0200, 16'h01FF);
            else if (k == 2) drive(1'b1, 16'hFE00, 16'h0005);
            else             drive(1'b1, 16'h0100, 16'hFF00);
            if (k == 8) begin
                total++; if (peak !== exp1) begin bad++; $display("FAIL peak_hold got=%0h exp=%0h", peak, exp1); end
            end
        end
        total++; if (peak !== exp2) begin bad++; $display("FAIL peak_win2 got=%0h exp=%0h", peak, exp2); end
        total++; if (clip_count !== 5'd0) begin bad++; $display("FAIL peak_win2_count got=%0d exp=0", clip_count); end
        strobe_in = 1'b0;
    endtask

    // clear together with clipped sample 5: excluded, but still passed through.
    task automatic test_clear_strobe();
        do_reset();
        for (int k = 1; k <= 4; k++) drive(1'b1, 16'h0100, 16'h0100);
        clear = 1'b1;
        drive(1'b1, 16'h7FFF, 16'h0100);
        clear = 1'b0;
        total++; if (clip_flag !== 1'b0) begin bad++; $display("FAIL clr_flag got=%0h exp=0", clip_flag); end
        total++; if (out_i !== 16'h7FFF) begin bad++; $display("FAIL clr_passthru got=%0h exp=7fff", out_i); end
        total++; if (window_done !== 1'b0) begin bad++; $display("FAIL clr_done got=%0h exp=0", window_done); end
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 16'h0100, 16'h0100);
            total++; if (window_done !== (k == 16)) begin bad++; $display("FAIL clr_restart k=%0d got=%0h exp=%0h", k, window_done, (k == 16)); end
        end
        total++; if (clip_count !== 5'd0) begin bad++; $display("FAIL clr_count got=%0d exp=0", clip_count); end
        total++; if (clip_flag !== 1'b0) begin bad++; $display("FAIL clr_flag_end got=%0h exp=0", clip_flag); end
        strobe_in = 1'b0;
    endtask

    // clear zeroes published stats; clear on the completing strobe suppresses window_done.
    task automatic test_clear_window_end();
        do_reset();
        for (int k = 1; k <= 16; k++) drive(1'b1, (k == 2) ? 16'h8000 : 16'h0001, 16'h0001);
        total++; if (clip_count !== 5'd1) begin bad++; $display("FAIL clrend_pre_count got=%0d exp=1", clip_count); end
        for (int k = 1; k <= 15; k++) drive(1'b1, 16'h7FFF, 16'h0001);
        clear = 1'b1;
        drive(1'b1, 16'h7FFF, 16'h0001);
        clear = 1'b0;
        total++; if (window_done !== 1'b0) begin bad++; $display("FAIL clrend_done got=%0h exp=0", window_done); end
        total++; if (clip_count !== 5'd0) begin bad++; $display("FAIL clrend_count got=%0d exp=0", clip_count); end
        total++; if (clip_flag !== 1'b0) begin bad++; $display("FAIL clrend_flag got=%0h exp=0", clip_flag); end
        drive(1'b0, 16'h0, 16'h0);
        total++; if (window_done !== 1'b0) begin bad++; $display("FAIL clrend_done_late got=%0h exp=0", window_done); end
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 16'h0001, 16'h0001);
            total++; if (window_done !== (k == 16)) begin bad++; $display("FAIL clrend_restart k=%0d got=%0h exp=%0h", k, window_done, (k == 16)); end
        end
        strobe_in = 1'b0;
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int k = 1; k <= 10; k++) drive(1'b1, (k <= 4) ? 16'h7FFF : 16'h0100, 16'h0100);
        total++; if (clip_flag !== 1'b1) begin bad++; $display("FAIL rstmid_pre_flag got=%0h exp=1", clip_flag); end
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0);
        rst = 1'b0;
        total++; if (clip_flag !== 1'b0) begin bad++; $display("FAIL rstmid_flag got=%0h exp=0", clip_flag); end
        total++; if (out_i !== 16'h0) begin bad++; $display("FAIL rstmid_out_i got=%0h exp=0", out_i); end
        total++; if (window_done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%0h exp=0", window_done); end
        total++; if (clip_count !== 5'd0) begin bad++; $display("FAIL rstmid_count got=%0d exp=0", clip_count); end
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, (k == 7) ? 16'h8000 : 16'h0100, 16'h0100);
            total++; if (window_done !== (k == 16)) begin bad++; $display("FAIL rstmid_win k=%0d got=%0h exp=%0h", k, window_done, (k == 16)); end
        end
        total++; if (clip_count !== 5'd1) begin bad++; $display("FAIL rstmid_next_count got=%0d exp=1", clip_count); end
        strobe_in = 1'b0;
    endtask

    // Every sample clipped, strobes 3 cycles apart: full-window count, no wrap.
    task automatic test_gaps();
        logic prev_s;
        do_reset();
        prev_s = 1'b0;
        for (int k = 0; k < 48; k++) begin
            drive((k % 3) == 0, 16'h7FFF, 16'h0000);
            total++; if (strobe_out !== ((k % 3) == 0)) begin bad++; $display("FAIL gaps_strobe_out k=%0d got=%0h exp=%0h", k, strobe_out, ((k % 3) == 0)); end
            total++; if (window_done !== (k == 45)) begin bad++; $display("FAIL gaps_done k=%0d got=%0h exp=%0h", k, window_done, (k == 45)); end
            prev_s = strobe_in;
        end
        total++; if (clip_count !== 5'd16) begin bad++; $display("FAIL gaps_count got=%0d exp=16", clip_count); end
        total++; if (strobe_out !== prev_s) begin bad++; $display("FAIL gaps_last_strobe got=%0h exp=%0h", strobe_out, prev_s); end
        strobe_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clip_window();
        test_continuous();
        test_peak();
        test_clear_strobe();
        test_clear_window_end();
        test_rst_mid();
        test_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
